// File: rtl/conv5_pkg.sv
// Shared constants and types for the 5x5 convolution line buffer.
// The kernel size and the phase-counter width are fixed by the PE array geometry.
package conv5_pkg;

    localparam int KSIZE   = 5;
    localparam int PHASE_W = 3;
    localparam int PIX_W   = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_t;

endpackage

// File: rtl/conv5_line_buffer_line_mem.sv
// One image line of pixel storage: a single-port RAM whose combinational read
// returns the contents from before the write that happens on the same edge.
module line_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // NOTE: the storage array has no reset; the FILL phase guarantees every
    // location is written before it is ever read into the output window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv5_line_buffer.sv
// Raster-order line buffer feeding the 5x5 PE array: four chained line RAMs
// plus counters, a FILL/STREAM FSM and registered window-column outputs.
module conv5_line_buffer
    import conv5_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    input  logic               s_sof,
    input  logic [DW-1:0]      s_pixel,
    output logic [DW-1:0]      R1,
    output logic [DW-1:0]      R2,
    output logic [DW-1:0]      R3,
    output logic [DW-1:0]      R4,
    output logic [DW-1:0]      R5,
    output logic [PHASE_W-1:0] sel,
    output logic               out_valid,
    output logic               frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    lb_state_t          state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [PHASE_W-1:0] phase;

    // A start-of-frame pixel overrides wherever the counters happen to be.
    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [PHASE_W-1:0] cur_phase;
    lb_state_t          cur_state;
    logic               last_col;
    logic               last_row;

    assign cur_col   = s_sof ? '0 : col;
    assign cur_row   = s_sof ? '0 : row;
    assign cur_phase = (cur_col == '0) ? '0 : phase;
    assign cur_state = s_sof ? FILL : state;
    assign last_col  = (cur_col == COL_W'(IMG_W - 1));
    assign last_row  = (cur_row == ROW_W'(IMG_H - 1));

    // taps[0..3] are L1..L4 read at the current column; taps[4] is the new pixel.
    logic [DW-1:0] taps [KSIZE];

    assign taps[KSIZE-1] = s_pixel;

    for (genvar i = 0; i < KSIZE - 1; i++) begin : g_lines
        line_mem #(
            .DW    (DW),
            .DEPTH (IMG_W)
        ) u_line (
            .clk   (clk),
            .we    (s_valid),
            .addr  (cur_col),
            .wdata (taps[i+1]),
            .rdata (taps[i])
        );
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            phase      <= '0;
            R1         <= '0;
            R2         <= '0;
            R3         <= '0;
            R4         <= '0;
            R5         <= '0;
            sel        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (s_valid) begin
                col   <= last_col ? '0 : cur_col + COL_W'(1);
                row   <= !last_col ? cur_row :
                         (last_row ? '0 : cur_row + ROW_W'(1));
                phase <= (cur_phase == PHASE_W'(KSIZE - 1)) ? '0 : cur_phase + PHASE_W'(1);
                case (cur_state)
                    FILL: begin
                        state <= (last_col && cur_row == ROW_W'(KSIZE - 2)) ? STREAM : FILL;
                    end
                    STREAM: begin
                        R1        <= taps[0];
                        R2        <= taps[1];
                        R3        <= taps[2];
                        R4        <= taps[3];
                        R5        <= taps[4];
                        sel       <= cur_phase;
                        out_valid <= 1'b1;
                        if (last_col && last_row) begin
                            state      <= FILL;
                            frame_done <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv5_line_buffer.sv
// Directed bench for conv5_line_buffer on an 8x6 image, pixel = row*16 + col.
module tb_conv5_line_buffer;
    import conv5_pkg::*;

    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic [DW-1:0] s_pixel = '0;
    logic [DW-1:0] R1, R2, R3, R4, R5;
    logic [2:0]    sel;
    logic          out_valid;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv5_line_buffer #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_pixel    (s_pixel),
        .R1         (R1),
        .R2         (R2),
        .R3         (R3),
        .R4         (R4),
        .R5         (R5),
        .sel        (sel),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    typedef logic [44:0] win_t;

    typedef struct {
        logic valid;
        logic sof;
        pix_t pix;
        win_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic win_t win(input pix_t r1, r2, r3, r4, r5,
                                 input logic [2:0] s, input logic ov, input logic fd);
        return {r1, r2, r3, r4, r5, s, ov, fd};
    endfunction

    function automatic win_t dut_win();
        return {R1, R2, R3, R4, R5, sel, out_valid, frame_done};
    endfunction

    function automatic pix_t pix(input int r, input int c);
        return pix_t'(r * 16 + c);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input pix_t p, input win_t e);
        vec_t t;
        t.valid = v;
        t.sof   = 1'b0;
        t.pix   = p;
        t.exp   = e;
        vecs.push_back(t);
    endtask

    // Drive one cycle of input, then sample just after the edge.
    task automatic step(input logic v, input logic sof, input pix_t p);
        s_valid = v;
        s_sof   = sof;
        s_pixel = p;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Sends rows 0..3 starting at linear index start; out_valid/frame_done must stay low.
    task automatic send_fill(input int start, input logic sof_first, input string name);
        for (int i = start; i < 4 * IMG_W; i++) begin
            step(1'b1, sof_first && (i == start), pix(i / IMG_W, i % IMG_W));
            check(name, {out_valid, frame_done}, 2'b00);
        end
    endtask

    initial begin
        // Row 4 with a 3-cycle gap after column 3.
        add(1, 8'h40, win(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 3'd0, 1, 0));
        add(1, 8'h41, win(8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 3'd1, 1, 0));
        add(1, 8'h42, win(8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 3'd2, 1, 0));
        add(1, 8'h43, win(8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 3'd3, 1, 0));
        add(0, 8'hff, win(8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 3'd3, 0, 0));
        add(0, 8'hff, win(8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 3'd3, 0, 0));
        add(0, 8'hff, win(8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 3'd3, 0, 0));
        add(1, 8'h44, win(8'h04, 8'h14, 8'h24, 8'h34, 8'h44, 3'd4, 1, 0));
        add(1, 8'h45, win(8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 3'd0, 1, 0));
        add(1, 8'h46, win(8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 3'd1, 1, 0));
        add(1, 8'h47, win(8'h07, 8'h17, 8'h27, 8'h37, 8'h47, 3'd2, 1, 0));
        // Row 5, ending the frame.
        add(1, 8'h50, win(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 3'd0, 1, 0));
        add(1, 8'h51, win(8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 3'd1, 1, 0));
        add(1, 8'h52, win(8'h12, 8'h22, 8'h32, 8'h42, 8'h52, 3'd2, 1, 0));
        add(1, 8'h53, win(8'h13, 8'h23, 8'h33, 8'h43, 8'h53, 3'd3, 1, 0));
        add(1, 8'h54, win(8'h14, 8'h24, 8'h34, 8'h44, 8'h54, 3'd4, 1, 0));
        add(1, 8'h55, win(8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 3'd0, 1, 0));
        add(1, 8'h56, win(8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 3'd1, 1, 0));
        add(1, 8'h57, win(8'h17, 8'h27, 8'h37, 8'h47, 8'h57, 3'd2, 1, 1));
        add(0, 8'h00, win(8'h17, 8'h27, 8'h37, 8'h47, 8'h57, 3'd2, 0, 0));

        // Reset while idle, then release with no input.
        reset = 1'b1;
        #12;
        check("reset_idle", dut_win(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_idle", dut_win(), '0);

        // Frame 1: fill, then the table covers rows 4 and 5.
        send_fill(0, 1'b1, "fill_frame1");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].sof, vecs[i].pix);
            check($sformatf("vec%0d", i), dut_win(), vecs[i].exp);
        end

        // Frame 2: new FILL after frame_done, then abort with s_sof at row 4, col 3.
        send_fill(0, 1'b1, "fill_frame2");
        step(1'b1, 1'b0, 8'h40);
        step(1'b1, 1'b0, 8'h41);
        step(1'b1, 1'b0, 8'h42);
        check("frame2_r4c2", dut_win(), win(8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 3'd2, 1, 0));
        step(1'b1, 1'b1, pix(0, 0));
        check("sof_mid_row", dut_win(), win(8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 3'd2, 0, 0));
        send_fill(1, 1'b0, "fill_after_sof");
        step(1'b1, 1'b0, 8'h40);
        check("restart_r4c0", dut_win(), win(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 3'd0, 1, 0));
        for (int c = 1; c < IMG_W; c++) begin
            step(1'b1, 1'b0, pix(4, c));
            check("restart_row4_fd", {out_valid, frame_done}, 2'b10);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, pix(5, c));
        end
        check("restart_r5c2", dut_win(), win(8'h12, 8'h22, 8'h32, 8'h42, 8'h52, 3'd2, 1, 0));

        // Asynchronous reset mid-row 5, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", dut_win(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_no_fd", dut_win(), '0);

        // The next pixel without s_sof must be treated as row 0, col 0.
        send_fill(0, 1'b0, "fill_after_reset");
        step(1'b1, 1'b0, 8'h40);
        check("after_reset_r4c0", dut_win(), win(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 3'd0, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv5_line_buffer.md
# conv5_line_buffer

- Upstream feeder for the 5x5 2-D multiply PE array.
- Accepts a raster-order 8-bit pixel stream and stores the four previous image lines.
- For every accepted pixel from row 4 onward, presents the five vertically aligned pixels (R1 oldest row … R5 current row), together with a column-phase `sel`, on the PE array's row inputs.
- Masks the fill period and flags end of frame.

## Interface
Parameters:
- `DW`, 8: pixel width.
- `IMG_W`, 32: pixels per line; must be ≥5.
- `IMG_H`, 32: lines per frame; must be ≥5.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input pixel valid; the pixel is accepted on every cycle it is high (no backpressure).
- `s_sof` in 1: start of frame, qualified by `s_valid`; the accompanying pixel is row 0, column 0.
- `s_pixel` in DW: input pixel.
- `R1`..`R5` out DW each: column-aligned pixels from rows r-4 … r.
- `sel` out 3: column phase 0..4 for the PE array.
- `out_valid` out 1: R1..R5/`sel` are a valid window column.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Counters:
  - `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1; both advance only on accepted pixels.
  - When `col` wraps, `row` increments.
  - When `row` and `col` both wrap, both return to 0.
- Line memories: four arrays of IMG_W×DW (L1 oldest … L4 newest), indexed by `col`.
- On an accepted pixel at column c:
  - Read L1[c]..L4[c], then shift: L1[c]←L2[c], L2[c]←L3[c], L3[c]←L4[c], L4[c]←pixel.
  - The reads see pre-write contents (read-before-write).
- FSM, two states:
  - FILL (row<4): memories are written, `out_valid`=0, R/`sel` hold.
  - STREAM (row≥4): each accepted pixel registers R1=L1[c], R2=L2[c], R3=L3[c], R4=L4[c], R5=pixel, sets `out_valid`=1 for one cycle and `sel`=current phase.
  - FILL→STREAM when the last pixel of row 3 is accepted.
  - STREAM→FILL when the last pixel of row IMG_H-1 is accepted; `frame_done` pulses the next cycle.
- `sel` phase:
  - Resets to 0 at column 0 of every row.
  - Increments per accepted pixel and wraps 4→0.
  - Emitted value = col mod 5.
- `s_valid` low: no counter or memory change; `out_valid`=0; R and `sel` hold their last values.
- `s_sof` with `s_valid`: forces `row`=0 and `col`=0, state FILL; the pixel is stored at column 0.
  - This applies at any point in a frame, including mid-row.
  - No `frame_done` is produced for the aborted frame.
- Arithmetic: counter widths are $clog2 of IMG_W/IMG_H; the phase counter is 3 bits. No pixel arithmetic; the data path is a pure copy.

## Timing
- Reset values:
  - R1..R5=0, `sel`=0, `out_valid`=0, `frame_done`=0.
  - `col`=`row`=0, phase=0, state FILL.
  - Line memory contents are not cleared; FILL masks them.
- Latency: accepted pixel at edge N → R/`sel`/`out_valid` valid after edge N+1 (1 cycle).
- Throughput: one window column per clock in STREAM.
- The first `out_valid` follows the pixel (row 4, col 0).
- Last pixel and `s_sof` in the same cycle: `s_sof` wins; no `frame_done`.
- Reset mid-frame clears state immediately, with no waiting for the clock; the next accepted pixel is treated as row 0, col 0.

## Structure
- Shared package (`conv5_pkg`):
  - `KSIZE`=5.
  - Phase width constant 3.
  - FSM state enum {FILL, STREAM}.
  - Pixel typedef `pix_t` (DW bits).
- Natural sub-module: `line_mem`, one IMG_W×DW single-port read-before-write RAM, instantiated four times and chained to form the L1..L4 shift.
- Top level holds the counters, FSM, phase counter and output registers.

## Test plan
Bench parameters: IMG_W=8, IMG_H=6; pixel value = row·16+col.
- Reset asserted while idle → all outputs 0; release, no input → outputs stay 0.
- Stream rows 0–3 continuously (32 pixels, `s_sof` on the first) → `out_valid` stays 0 throughout.
- Row 4, col 2 accepted → next cycle R1=0x02, R2=0x12, R3=0x22, R4=0x32, R5=0x42, `sel`=2, `out_valid`=1.
- Row 5, col 5 → `sel`=0 (wrap). Row 5, col 0 → `sel`=0 and R5=0x50.
- Insert 3-cycle `s_valid` gaps mid-row 4 → `out_valid`=0 during the gaps, R/`sel` held, and the next pixel continues with the correct column.
- Last pixel (row 5, col 7) → R5=0x57 plus a one-cycle `frame_done`.
  - A following `s_sof` frame restarts FILL: no `out_valid` for the next 32 pixels.
- `s_sof` at row 4, col 3 → restart; `reset` pulse mid-row 5 → all outputs 0 asynchronously, with no `frame_done` in either case.
